// File: rtl/eeg_acc_seq_pkg.sv
// Shared constants and types for the EEG accelerator command/frame sequencer.
package eeg_acc_seq_pkg;

  // Command opcodes carried in IN_DAT[7:4] of a command beat.
  localparam logic [3:0] OP_WR    = 4'h1;
  localparam logic [3:0] OP_START = 4'h2;
  localparam logic [3:0] OP_ABORT = 4'h3;

  // Configuration register addresses carried in the WR argument nibble.
  localparam logic [3:0] ADDR_LEN_LO  = 4'h0;
  localparam logic [3:0] ADDR_LEN_HI  = 4'h1;
  localparam logic [3:0] ADDR_FRM_NUM = 4'h2;
  localparam logic [3:0] ADDR_MODE    = 4'h3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CFG_VAL  = 2'd1,
    RUN      = 2'd2,
    WAIT_OUT = 2'd3
  } state_t;

endpackage

// File: rtl/eeg_acc_seq_if.sv
// Valid/ready beat stream with last and command qualifiers.
interface eeg_acc_seq_if #(
  parameter int DW = 8
);
  logic          vld;
  logic          rdy;
  logic          lst;
  logic          cmd;
  logic [DW-1:0] dat;

  modport master (output vld, lst, cmd, dat, input rdy);
  modport slave  (input vld, lst, cmd, dat, output rdy);
endinterface

// File: rtl/eeg_seq_cfg_regs.sv
// Configuration register file: frame length (two bytes), frame count, mode.
// LEN_W must lie in 9..16 so that the high byte register fits.
module eeg_seq_cfg_regs
  import eeg_acc_seq_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [3:0]       addr_i,
  input  logic [7:0]       val_i,
  output logic [LEN_W-1:0] frm_len_o,
  output logic [7:0]       frm_num_o,
  output logic [7:0]       mode_o,
  output logic             addr_bad_o
);

  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       num_q, num_d;
  logic [7:0]       mode_q, mode_d;

  // Address decode and write-strobe gating of the next register values.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    len_d      = len_q;
    num_d      = num_q;
    mode_d     = mode_q;
    addr_bad_o = 1'b0;
    if (wr_en_i) begin
      case (addr_i)
        ADDR_LEN_LO:  len_d[7:0]       = val_i;
        ADDR_LEN_HI:  len_d[LEN_W-1:8] = val_i[LEN_W-9:0];
        ADDR_FRM_NUM: num_d            = val_i;
        ADDR_MODE:    mode_d           = val_i;
        default:      addr_bad_o       = 1'b1;
      endcase
    end
  end

  // Register update; defaults give a legal one-beat, one-frame run.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge, so it sits inside the clocked branch, not the sensitivity list.
    if (!rst_n) begin
      len_q  <= LEN_W'(1);
      num_q  <= 8'd1;
      mode_q <= 8'd0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      len_q  <= len_d;
      num_q  <= num_d;
      mode_q <= mode_d;
    end
  end

  assign frm_len_o = len_q;
  assign frm_num_o = num_q;
  assign mode_o    = mode_q;

endmodule

// File: rtl/eeg_acc_seq.sv
// Command/frame sequencer: decodes command beats into configuration and
// START/ABORT, then gates data beats into the accelerator in frames.
module eeg_acc_seq
  import eeg_acc_seq_pkg::*;
#(
  parameter int DW    = 8,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  eeg_acc_seq_if.slave     in_s,
  eeg_acc_seq_if.master    acc_m,
  input  logic             acc_out_vld_i,
  input  logic             acc_out_lst_i,
  input  logic             acc_out_rdy_i,
  output logic [LEN_W-1:0] cfg_frm_len_o,
  output logic [7:0]       cfg_frm_num_o,
  output logic [7:0]       cfg_mode_o,
  output logic             busy_o,
  output logic             err_o
);

  state_t           state_q;
  logic [LEN_W-1:0] beat_cnt_q;
  logic [7:0]       frm_cnt_q;
  logic [3:0]       addr_q;
  logic             busy_q;
  logic             err_q;

  logic       in_rdy;
  logic       in_xfer;
  logic       last_beat;
  logic       out_last;
  logic       cfg_wr;
  logic       addr_bad;
  logic [3:0] opcode;
  logic [3:0] arg;

  assign opcode    = in_s.dat[7:4];
  assign arg       = in_s.dat[3:0];
  assign in_xfer   = in_s.vld & in_rdy;
  assign last_beat = (beat_cnt_q == LEN_W'(cfg_frm_len_o - LEN_W'(1)));
  assign out_last  = acc_out_vld_i & acc_out_rdy_i & acc_out_lst_i;
  assign cfg_wr    = (state_q == CFG_VAL) & in_xfer & in_s.cmd;

  eeg_seq_cfg_regs #(.LEN_W(LEN_W)) u_cfg_regs (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (cfg_wr),
    .addr_i     (addr_q),
    .val_i      (in_s.dat[7:0]),
    .frm_len_o  (cfg_frm_len_o),
    .frm_num_o  (cfg_frm_num_o),
    .mode_o     (cfg_mode_o),
    .addr_bad_o (addr_bad)
  );

  // Zero-latency stream gating: data passes straight through only in RUN.
  always_comb begin
    in_rdy    = 1'b1;
    acc_m.vld = 1'b0;
    acc_m.lst = 1'b0;
    acc_m.cmd = 1'b0;
    acc_m.dat = in_s.dat;
    case (state_q)
      RUN: begin
        in_rdy    = in_s.cmd ? 1'b1 : acc_m.rdy;
        acc_m.vld = in_s.vld & ~in_s.cmd;
        acc_m.lst = last_beat;
      end
      WAIT_OUT: in_rdy = 1'b0;
      default:  ;
    endcase
  end

  assign in_s.rdy = in_rdy;

  // Sequencer FSM with beat/frame counters and registered BUSY/ERR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      frm_cnt_q  <= '0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_xfer) begin
          if (!in_s.cmd) begin
            err_q <= 1'b1;
          end else begin
            case (opcode)
              OP_WR: begin
                addr_q  <= arg;
                state_q <= CFG_VAL;
              end
              OP_START: begin
                if (cfg_frm_len_o == '0 || cfg_frm_num_o == '0) begin
                  err_q <= 1'b1;
                end else begin
                  state_q    <= RUN;
                  busy_q     <= 1'b1;
                  beat_cnt_q <= '0;
                  frm_cnt_q  <= '0;
                end
              end
              OP_ABORT: ;
              default:  err_q <= 1'b1;
            endcase
          end
        end
        CFG_VAL: if (in_xfer) begin
          if (in_s.cmd) begin
            state_q <= IDLE;
            if (addr_bad) err_q <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        end
        RUN: if (in_xfer) begin
          if (in_s.cmd) begin
            if (opcode == OP_ABORT) begin
              state_q    <= IDLE;
              busy_q     <= 1'b0;
              beat_cnt_q <= '0;
              frm_cnt_q  <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end else begin
            if (in_s.lst != last_beat) err_q <= 1'b1;
            if (last_beat) begin
              beat_cnt_q <= '0;
              state_q    <= WAIT_OUT;
            end else begin
              beat_cnt_q <= beat_cnt_q + LEN_W'(1);
            end
          end
        end
        WAIT_OUT: if (out_last) begin
          if (frm_cnt_q + 8'd1 == cfg_frm_num_o) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            frm_cnt_q <= '0;
          end else begin
            state_q   <= RUN;
            frm_cnt_q <= frm_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_eeg_acc_seq.sv
// Directed bench for eeg_acc_seq with a frame-level reference model that is
// compared against the DUT outputs on every falling clock edge.
module tb_eeg_acc_seq;
  import eeg_acc_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eeg_acc_seq_if #(.DW(8)) in_if ();
  eeg_acc_seq_if #(.DW(8)) acc_if ();

  logic        ovld, olst, ordy;
  logic [15:0] cfg_len;
  logic [7:0]  cfg_num, cfg_mode;
  logic        busy, err;

  eeg_acc_seq #(.DW(8), .LEN_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_s          (in_if),
    .acc_m         (acc_if),
    .acc_out_vld_i (ovld),
    .acc_out_lst_i (olst),
    .acc_out_rdy_i (ordy),
    .cfg_frm_len_o (cfg_len),
    .cfg_frm_num_o (cfg_num),
    .cfg_mode_o    (cfg_mode),
    .busy_o        (busy),
    .err_o         (err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame-level view) ----------------
  bit m_busy = 0, m_wait = 0, m_err = 0;
  int m_pend = -1;           // register address awaiting its value, -1 if none
  int m_beat = 0, m_frame = 0;
  int m_len = 1, m_num = 1, m_mode = 0;

  // Observed accelerator transfers.
  int n_acc = 0;
  int lst_pos[$];
  int dq[$];

  bit e_rdy, e_vld, xfer;
  int op, val;

  always @(negedge clk) begin
    e_rdy = m_wait ? 1'b0 : (m_busy ? (in_if.cmd ? 1'b1 : acc_if.rdy) : 1'b1);
    e_vld = m_busy && !m_wait && in_if.vld && !in_if.cmd;
    check("in_rdy", 32'(in_if.rdy), 32'(e_rdy));
    check("acc_vld", 32'(acc_if.vld), 32'(e_vld));
    if (e_vld) begin
      check("acc_dat", 32'(acc_if.dat), 32'(in_if.dat));
      check("acc_lst", 32'(acc_if.lst), 32'(m_beat == m_len - 1));
    end
    check("busy", 32'(busy), 32'(m_busy));
    check("err", 32'(err), 32'(m_err));
    check("cfg_len", 32'(cfg_len), 32'(m_len));
    check("cfg_num", 32'(cfg_num), 32'(m_num));
    check("cfg_mode", 32'(cfg_mode), 32'(m_mode));

    // Advance the model to the state after the coming rising edge.
    xfer = in_if.vld && e_rdy;
    op   = int'(in_if.dat) >> 4;
    val  = int'(in_if.dat);
    if (!rst_n) begin
      m_busy = 0; m_wait = 0; m_err = 0; m_pend = -1;
      m_beat = 0; m_frame = 0; m_len = 1; m_num = 1; m_mode = 0;
    end else if (m_wait) begin
      if (ovld && ordy && olst) begin
        m_wait = 0;
        if (m_frame + 1 == m_num) begin m_busy = 0; m_frame = 0; end
        else m_frame++;
      end
    end else if (m_busy) begin
      if (xfer && in_if.cmd) begin
        if (op == 3) begin m_busy = 0; m_beat = 0; m_frame = 0; end
        else m_err = 1;
      end else if (xfer) begin
        if (in_if.lst != (m_beat == m_len - 1)) m_err = 1;
        if (m_beat == m_len - 1) begin m_beat = 0; m_wait = 1; end
        else m_beat++;
      end
    end else if (xfer) begin
      if (m_pend >= 0) begin
        if (!in_if.cmd) m_err = 1;
        else begin
          case (m_pend)
            0: m_len = (m_len & 32'hFF00) | val;
            1: m_len = (m_len & 32'h00FF) | (val << 8);
            2: m_num = val;
            3: m_mode = val;
            default: m_err = 1;
          endcase
          m_pend = -1;
        end
      end else if (!in_if.cmd) m_err = 1;
      else if (op == 1) m_pend = val & 15;
      else if (op == 2) begin
        if (m_len == 0 || m_num == 0) m_err = 1;
        else begin m_busy = 1; m_beat = 0; m_frame = 0; end
      end else if (op != 3) m_err = 1;
    end
  end

  // Record each beat actually accepted by the accelerator.
  always @(negedge clk) begin
    if (acc_if.vld && acc_if.rdy) begin
      n_acc++;
      dq.push_back(int'(acc_if.dat));
      if (acc_if.lst) lst_pos.push_back(n_acc);
    end
  end

  // Accelerator ready: steady high, or toggling every cycle when enabled.
  bit tog_en = 0;
  initial begin
    acc_if.rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      acc_if.rdy = tog_en ? ~acc_if.rdy : 1'b1;
    end
  end

  // ---------------- stimulus helpers (drive at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input bit cmd, input logic [7:0] dat, input bit lst);
    bit done = 0;
    int n = 0;
    in_if.vld = 1'b1; in_if.cmd = cmd; in_if.dat = dat; in_if.lst = lst;
    while (!done) begin
      @(negedge clk);
      done = in_if.rdy;
      @(posedge clk); #1;
      n++;
      if (!done && n > 100) begin
        total++; bad++;
        $display("FAIL send_timeout: got no in_rdy, want a transfer within 100 cycles");
        done = 1;
      end
    end
    in_if.vld = 1'b0; in_if.cmd = 1'b0; in_if.lst = 1'b0;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [7:0] v);
    send(1'b1, {OP_WR, addr}, 1'b0);
    send(1'b1, v, 1'b0);
  endtask

  task automatic start();  send(1'b1, {OP_START, 4'h0}, 1'b0); endtask
  task automatic abort();  send(1'b1, {OP_ABORT, 4'h0}, 1'b0); endtask

  task automatic out_last();
    ovld = 1'b1; olst = 1'b1; ordy = 1'b1;
    idle(1);
    ovld = 1'b0; olst = 1'b0; ordy = 1'b0;
  endtask

  task automatic clear_obs();
    n_acc = 0; lst_pos.delete(); dq.delete();
  endtask

  // Data beats base+1..base+n, IN_LST asserted where mask bit (k-1) is set.
  task automatic frame(input int base, input int n, input int mask);
    for (int k = 1; k <= n; k++) send(1'b0, 8'(base + k), mask[k-1]);
  endtask

  task automatic to_neg();  @(negedge clk);  endtask
  task automatic to_drive(); @(posedge clk); #1; endtask

  // Checks shared by the two 2x4-beat runs.
  task automatic check_two_frames(input string tag);
    check({tag, "_n_acc"}, 32'(n_acc), 32'd8);
    check({tag, "_lst_cnt"}, 32'(lst_pos.size()), 32'd2);
    if (lst_pos.size() == 2) begin
      check({tag, "_lst_a"}, 32'(lst_pos[0]), 32'd4);
      check({tag, "_lst_b"}, 32'(lst_pos[1]), 32'd8);
    end
    for (int k = 0; k < dq.size(); k++) check({tag, "_dat"}, 32'(dq[k]), 32'(k + 1));
  endtask

  initial begin
    in_if.vld = 1'b0; in_if.cmd = 1'b0; in_if.lst = 1'b0; in_if.dat = 8'h00;
    ovld = 1'b0; olst = 1'b0; ordy = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Reset state.
    to_neg();
    check("rst_in_rdy", 32'(in_if.rdy), 32'd1);
    check("rst_acc_vld", 32'(acc_if.vld), 32'd0);
    check("rst_len", 32'(cfg_len), 32'd1);
    check("rst_num", 32'(cfg_num), 32'd1);
    check("rst_mode", 32'(cfg_mode), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    to_drive();

    // Two frames of four beats with steady accelerator ready.
    wr(4'h0, 8'h04); wr(4'h1, 8'h00); wr(4'h2, 8'h02); wr(4'h3, 8'h5A);
    to_neg();
    check("cfg_len_4", 32'(cfg_len), 32'd4);
    check("cfg_num_2", 32'(cfg_num), 32'd2);
    check("cfg_mode_5a", 32'(cfg_mode), 32'h5A);
    to_drive();
    clear_obs();
    start();
    frame(0, 4, 4'b1000);
    idle(2);
    to_neg();
    check("wait_in_rdy", 32'(in_if.rdy), 32'd0);
    check("wait_busy", 32'(busy), 32'd1);
    to_drive();
    out_last();
    frame(4, 4, 4'b1000);
    out_last();
    to_neg();
    check("t1_busy_done", 32'(busy), 32'd0);
    check("t1_err", 32'(err), 32'd0);
    check_two_frames("t1");
    to_drive();

    // Same run with accelerator ready toggling every cycle.
    clear_obs();
    tog_en = 1;
    start();
    frame(0, 4, 4'b1000);
    out_last();
    frame(4, 4, 4'b1000);
    out_last();
    tog_en = 0;
    idle(1);
    to_neg();
    check("t2_busy_done", 32'(busy), 32'd0);
    check_two_frames("t2");
    to_drive();

    // START with zero frame length is refused.
    wr(4'h0, 8'h00);
    start();
    to_neg();
    check("len0_err", 32'(err), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    check("len0_in_rdy", 32'(in_if.rdy), 32'd1);
    to_drive();
    rst_n = 1'b0; idle(1); rst_n = 1'b1;

    // ABORT after two beats, then restart from beat 0.
    wr(4'h0, 8'h04); wr(4'h2, 8'h01);
    clear_obs();
    start();
    frame(0, 2, 0);
    abort();
    to_neg();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_no_lst", 32'(lst_pos.size()), 32'd0);
    to_drive();
    clear_obs();
    start();
    frame(0, 4, 4'b1000);
    out_last();
    to_neg();
    check("restart_lst_cnt", 32'(lst_pos.size()), 32'd1);
    if (lst_pos.size() == 1) check("restart_lst_pos", 32'(lst_pos[0]), 32'd4);
    check("restart_err", 32'(err), 32'd0);
    check("restart_busy", 32'(busy), 32'd0);
    to_drive();

    // Early IN_LST on beat 2 flags ERR; frame still closes on beat 4.
    clear_obs();
    start();
    frame(0, 4, 4'b1010);
    to_neg();
    check("early_lst_err", 32'(err), 32'd1);
    check("early_lst_cnt", 32'(lst_pos.size()), 32'd1);
    if (lst_pos.size() == 1) check("early_lst_pos", 32'(lst_pos[0]), 32'd4);
    to_drive();
    out_last();

    // LEN=1: every beat carries last.
    wr(4'h0, 8'h01); wr(4'h2, 8'h02);
    clear_obs();
    start();
    frame(0, 1, 1);
    out_last();
    frame(1, 1, 1);
    out_last();
    to_neg();
    check("len1_lst_cnt", 32'(lst_pos.size()), 32'd2);
    if (lst_pos.size() == 2) check("len1_lst_b", 32'(lst_pos[1]), 32'd2);
    check("len1_busy", 32'(busy), 32'd0);
    to_drive();

    // Reset while waiting for the output last.
    wr(4'h0, 8'h04); wr(4'h2, 8'h01); wr(4'h3, 8'h77);
    start();
    frame(0, 4, 4'b1000);
    to_neg();
    check("pre_rst_busy", 32'(busy), 32'd1);
    to_drive();
    rst_n = 1'b0; idle(1); rst_n = 1'b1;
    to_neg();
    check("mid_rst_len", 32'(cfg_len), 32'd1);
    check("mid_rst_num", 32'(cfg_num), 32'd1);
    check("mid_rst_mode", 32'(cfg_mode), 32'd0);
    check("mid_rst_in_rdy", 32'(in_if.rdy), 32'd1);
    check("mid_rst_acc_vld", 32'(acc_if.vld), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    to_drive();
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
